// File: rtl/fwd_hazard_unit.sv
// Operand forwarding, load-use and MDU hazard detection with stall counter.
// Optional MDU scoreboard enabled by defining HAZ_MDU_EN.
module fwd_hazard_unit #(
  parameter int REG_AW  = 6,
  parameter int NSRC    = 2,
  parameter int MDU_LAT = 4,
  parameter int CNT_W   = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NSRC*REG_AW-1:0] id_src,
  input  logic [NSRC-1:0]        id_src_used,
  input  logic                   id_is_mdu,
  input  logic [NSRC*REG_AW-1:0] idex_src,
  input  logic                   idex_regwr,
  input  logic                   idex_memrd,
  input  logic [REG_AW-1:0]      idex_rdes,
  input  logic                   exmem_regwr,
  input  logic [REG_AW-1:0]      exmem_rdes,
  input  logic                   memwb_regwr,
  input  logic [REG_AW-1:0]      memwb_rdes,
  input  logic                   mdu_start,
  input  logic [REG_AW-1:0]      mdu_rdes,
  input  logic                   flush,
  input  logic                   cnt_clr,
  output logic [2*NSRC-1:0]      fwd_sel,
  output logic                   stall,
  output logic                   mdu_busy,
  output logic                   mdu_done,
  output logic                   mdu_ovr,
  output logic [CNT_W-1:0]       stall_cnt
);

  if (NSRC < 1 || NSRC > 4) begin : g_bad_nsrc
    $error("fwd_hazard_unit: NSRC must be 1..4");
  end

  if (MDU_LAT < 2 || MDU_LAT > 15) begin : g_bad_lat
    $error("fwd_hazard_unit: MDU_LAT must be 2..15");
  end

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [NSRC-1:0] ex_hit;
  logic [NSRC-1:0] wb_hit;
  logic [NSRC-1:0] lu_hit;
  logic            ex_ok;
  logic            wb_ok;
  logic            lu_ok;
  logic            load_use;
  logic            mdu_haz;

  // Writers of r0 never forward and never create a hazard.
  assign ex_ok = exmem_regwr && (exmem_rdes != '0);
  assign wb_ok = memwb_regwr && (memwb_rdes != '0);
  assign lu_ok = idex_memrd && idex_regwr && (idex_rdes != '0);

  for (genvar i = 0; i < NSRC; i++) begin : g_src
    logic [REG_AW-1:0] ex_src;
    logic [REG_AW-1:0] rd_src;

    assign ex_src = idex_src[i*REG_AW +: REG_AW];
    assign rd_src = id_src[i*REG_AW +: REG_AW];

    assign ex_hit[i] = ex_ok && (exmem_rdes == ex_src);
    assign wb_hit[i] = wb_ok && (memwb_rdes == ex_src);
    assign lu_hit[i] = id_src_used[i] && (rd_src == idex_rdes);

    // Younger EX/MEM result takes priority over MEM/WB.
    assign fwd_sel[2*i +: 2] = ex_hit[i] ? 2'b10 :
                               wb_hit[i] ? 2'b01 : 2'b00;
  end

  assign load_use = lu_ok && (|lu_hit);

`ifdef HAZ_MDU_EN

  localparam logic [3:0] LAT4 = 4'(MDU_LAT);

  logic [3:0]        mdu_cnt;
  logic [REG_AW-1:0] mdu_rd;
  logic              ovr_q;
  logic [NSRC-1:0]   rd_hit;
  logic [NSRC-1:0]   iss_hit;

  for (genvar i = 0; i < NSRC; i++) begin : g_mdu
    logic [REG_AW-1:0] rd_src;

    assign rd_src     = id_src[i*REG_AW +: REG_AW];
    assign rd_hit[i]  = id_src_used[i] && (rd_src == mdu_rd);
    assign iss_hit[i] = id_src_used[i] && (rd_src == mdu_rdes);
  end

  // Scoreboard: load on idle issue, count down to completion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mdu_cnt <= '0;
      mdu_rd  <= '0;
    end else if (mdu_start && (mdu_cnt == '0)) begin
      mdu_cnt <= LAT4;
      mdu_rd  <= mdu_rdes;
    end else if (mdu_cnt != '0) begin
      mdu_cnt <= mdu_cnt - 4'd1;
    end
  end

  // Sticky overrun: an issue arrived while a result was pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ovr_q <= 1'b0;
    end else if (mdu_start && (mdu_cnt != '0)) begin
      ovr_q <= 1'b1;
    end
  end

  assign mdu_busy = (mdu_cnt != '0);
  assign mdu_done = (mdu_cnt == 4'd1);
  assign mdu_ovr  = ovr_q;

  assign mdu_haz =
    (mdu_busy && (id_is_mdu ||
                  ((mdu_rd != '0) && (|rd_hit)))) ||
    (mdu_start && (mdu_rdes != '0) && (|iss_hit));

`else

  logic unused_mdu;

  assign unused_mdu = ^{mdu_start, mdu_rdes, id_is_mdu};
  assign mdu_busy   = 1'b0;
  assign mdu_done   = 1'b0;
  assign mdu_ovr    = 1'b0;
  assign mdu_haz    = 1'b0;

`endif

  // A killed ID instruction has nothing to wait for.
  assign stall = (load_use || mdu_haz) && !flush;

  // Saturating stall-cycle counter; clear wins over increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (cnt_clr) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: vector table, random run
// against a timestamp-based model, and hand-written multi-cycle sequences.
module tb_fwd_hazard_unit;

  localparam int AW  = 6;
  localparam int NS  = 2;
  localparam int LAT = 4;
  localparam int CW  = 4;

`ifdef HAZ_MDU_EN
  localparam bit MDU = 1'b1;
`else
  localparam bit MDU = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset;
  logic [NS*AW-1:0]  id_src;
  logic [NS-1:0]     id_src_used;
  logic              id_is_mdu;
  logic [NS*AW-1:0]  idex_src;
  logic              idex_regwr;
  logic              idex_memrd;
  logic [AW-1:0]     idex_rdes;
  logic              exmem_regwr;
  logic [AW-1:0]     exmem_rdes;
  logic              memwb_regwr;
  logic [AW-1:0]     memwb_rdes;
  logic              mdu_start;
  logic [AW-1:0]     mdu_rdes;
  logic              flush;
  logic              cnt_clr;
  logic [2*NS-1:0]   fwd_sel;
  logic              stall;
  logic              mdu_busy;
  logic              mdu_done;
  logic              mdu_ovr;
  logic [CW-1:0]     stall_cnt;

  fwd_hazard_unit #(
    .REG_AW(AW), .NSRC(NS), .MDU_LAT(LAT), .CNT_W(CW)
  ) dut (
    .clk(clk), .reset(reset),
    .id_src(id_src), .id_src_used(id_src_used),
    .id_is_mdu(id_is_mdu), .idex_src(idex_src),
    .idex_regwr(idex_regwr), .idex_memrd(idex_memrd),
    .idex_rdes(idex_rdes),
    .exmem_regwr(exmem_regwr), .exmem_rdes(exmem_rdes),
    .memwb_regwr(memwb_regwr), .memwb_rdes(memwb_rdes),
    .mdu_start(mdu_start), .mdu_rdes(mdu_rdes),
    .flush(flush), .cnt_clr(cnt_clr),
    .fwd_sel(fwd_sel), .stall(stall),
    .mdu_busy(mdu_busy), .mdu_done(mdu_done),
    .mdu_ovr(mdu_ovr), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int total  = 0;
  int passed = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic zero_inputs();
    id_src = '0; id_src_used = '0; id_is_mdu = 0;
    idex_src = '0; idex_regwr = 0; idex_memrd = 0;
    idex_rdes = '0; exmem_regwr = 0; exmem_rdes = '0;
    memwb_regwr = 0; memwb_rdes = '0; mdu_start = 0;
    mdu_rdes = '0; flush = 0; cnt_clr = 0;
  endtask

  task automatic do_reset();
    zero_inputs();
    reset = 1;
    step();
    reset = 0;
  endtask

  typedef struct {
    logic [AW-1:0] s0, s1;
    logic [1:0]    used;
    logic [AW-1:0] x0, x1;
    logic          xw, xm;
    logic [AW-1:0] xd;
    logic          ew;
    logic [AW-1:0] ed;
    logic          ww;
    logic [AW-1:0] wd;
    logic          fl;
    logic [3:0]    ef;
    logic          es;
  } vec_t;

  function automatic vec_t mk(
    int s0, int s1, int used, int x0, int x1,
    int xw, int xm, int xd, int ew, int ed,
    int ww, int wd, int fl, int ef, int es);
    vec_t v;
    v.s0 = AW'(s0); v.s1 = AW'(s1); v.used = 2'(used);
    v.x0 = AW'(x0); v.x1 = AW'(x1);
    v.xw = 1'(xw); v.xm = 1'(xm); v.xd = AW'(xd);
    v.ew = 1'(ew); v.ed = AW'(ed);
    v.ww = 1'(ww); v.wd = AW'(wd);
    v.fl = 1'(fl); v.ef = 4'(ef); v.es = 1'(es);
    return v;
  endfunction

  vec_t tbl[10];

  // Reference state: issue timestamp instead of a down-counter.
  int            cyc;
  int            iss;
  logic [AW-1:0] m_rd;
  bit            m_ovr;
  int            m_cnt;

  function automatic logic [AW-1:0] fld(
    logic [NS*AW-1:0] v, int i);
    return v[i*AW +: AW];
  endfunction

  function automatic bit m_busy();
    return MDU && iss >= 0 && cyc > iss && cyc <= iss + LAT;
  endfunction

  function automatic bit reads(logic [AW-1:0] r);
    bit hit = 0;
    for (int i = 0; i < NS; i++)
      if (id_src_used[i] && fld(id_src, i) == r) hit = 1;
    return hit;
  endfunction

  function automatic logic [3:0] m_fwd();
    logic [3:0] f = '0;
    for (int i = 0; i < NS; i++) begin
      logic [AW-1:0] s = fld(idex_src, i);
      if (exmem_regwr && exmem_rdes != 0 && exmem_rdes == s)
        f[2*i +: 2] = 2'b10;
      else if (memwb_regwr && memwb_rdes != 0 && memwb_rdes == s)
        f[2*i +: 2] = 2'b01;
    end
    return f;
  endfunction

  function automatic bit m_stall();
    bit lu, mh;
    lu = idex_memrd && idex_regwr && idex_rdes != 0 &&
         reads(idex_rdes);
    mh = 0;
    if (MDU) begin
      if (m_busy() && (id_is_mdu || (m_rd != 0 && reads(m_rd))))
        mh = 1;
      if (mdu_start && mdu_rdes != 0 && reads(mdu_rdes))
        mh = 1;
    end
    return (lu || mh) && !flush;
  endfunction

  initial begin
    reset = 1;
    zero_inputs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_cnt", 32'(stall_cnt), 0);
    chk("rst_busy", 32'(mdu_busy), 0);
    chk("rst_done", 32'(mdu_done), 0);
    chk("rst_ovr", 32'(mdu_ovr), 0);
    chk("rst_stall", 32'(stall), 0);
    chk("rst_fwd", 32'(fwd_sel), 0);
    reset = 0;
    step();

    tbl[0] = mk(0, 0, 0, 5, 0, 0, 0, 0, 1, 5, 1, 5, 0, 4'b0010, 0);
    tbl[1] = mk(0, 0, 0, 5, 0, 0, 0, 0, 0, 5, 1, 5, 0, 4'b0001, 0);
    tbl[2] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 4'b0000, 0);
    tbl[3] = mk(0, 8, 3, 0, 0, 1, 1, 8, 0, 0, 0, 0, 0, 4'b0000, 1);
    tbl[4] = mk(0, 8, 1, 0, 0, 1, 1, 8, 0, 0, 0, 0, 0, 4'b0000, 0);
    tbl[5] = mk(0, 8, 3, 0, 0, 1, 1, 8, 0, 0, 0, 0, 1, 4'b0000, 0);
    tbl[6] = mk(0, 0, 3, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 4'b0000, 0);
    tbl[7] = mk(0, 8, 3, 0, 0, 1, 0, 8, 0, 0, 0, 0, 0, 4'b0000, 0);
    tbl[8] = mk(0, 0, 0, 9, 7, 0, 0, 0, 1, 7, 1, 9, 0, 4'b1001, 0);
    tbl[9] = mk(4, 0, 1, 7, 7, 1, 1, 4, 1, 7, 1, 7, 0, 4'b1010, 1);

    for (int k = 0; k < 10; k++) begin
      id_src      = {tbl[k].s1, tbl[k].s0};
      id_src_used = tbl[k].used;
      idex_src    = {tbl[k].x1, tbl[k].x0};
      idex_regwr  = tbl[k].xw;
      idex_memrd  = tbl[k].xm;
      idex_rdes   = tbl[k].xd;
      exmem_regwr = tbl[k].ew;
      exmem_rdes  = tbl[k].ed;
      memwb_regwr = tbl[k].ww;
      memwb_rdes  = tbl[k].wd;
      flush       = tbl[k].fl;
      #1;
      chk($sformatf("vec%0d_fwd", k), 32'(fwd_sel), 32'(tbl[k].ef));
      chk($sformatf("vec%0d_stall", k), 32'(stall), 32'(tbl[k].es));
    end

    do_reset();
    cyc = 0; iss = -1; m_rd = '0; m_ovr = 0; m_cnt = 0;
    for (int n = 0; n < 300; n++) begin
      bit es;
      bit bz;
      id_src      = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
      id_src_used = 2'($urandom_range(0, 3));
      id_is_mdu   = ($urandom_range(0, 3) == 0);
      idex_src    = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
      idex_regwr  = 1'($urandom_range(0, 1));
      idex_memrd  = 1'($urandom_range(0, 1));
      idex_rdes   = AW'($urandom_range(0, 3));
      exmem_regwr = 1'($urandom_range(0, 1));
      exmem_rdes  = AW'($urandom_range(0, 3));
      memwb_regwr = 1'($urandom_range(0, 1));
      memwb_rdes  = AW'($urandom_range(0, 3));
      mdu_start   = ($urandom_range(0, 5) == 0);
      mdu_rdes    = AW'($urandom_range(0, 3));
      flush       = ($urandom_range(0, 4) == 0);
      cnt_clr     = ($urandom_range(0, 9) == 0);
      #1;
      es = m_stall();
      bz = m_busy();
      chk("rnd_fwd", 32'(fwd_sel), 32'(m_fwd()));
      chk("rnd_stall", 32'(stall), 32'(es));
      chk("rnd_busy", 32'(mdu_busy), 32'(bz));
      chk("rnd_done", 32'(mdu_done),
          32'(MDU && iss >= 0 && cyc == iss + LAT));
      chk("rnd_ovr", 32'(mdu_ovr), 32'(m_ovr));
      chk("rnd_cnt", 32'(stall_cnt), 32'(m_cnt));
      if (MDU && mdu_start) begin
        if (bz) m_ovr = 1;
        else begin
          iss = cyc;
          m_rd = mdu_rdes;
        end
      end
      if (cnt_clr) m_cnt = 0;
      else if (es && m_cnt < 15) m_cnt++;
      step();
      cyc++;
    end

    do_reset();
    idex_memrd = 1; idex_regwr = 1; idex_rdes = 8;
    id_src = {6'd8, 6'd0}; id_src_used = 2'b10;
    for (int c = 1; c <= 20; c++) begin
      step();
      chk($sformatf("sat_cnt_c%0d", c), 32'(stall_cnt),
          32'(c < 15 ? c : 15));
    end
    cnt_clr = 1;
    #1;
    chk("clr_stall", 32'(stall), 1);
    step();
    chk("clr_cnt", 32'(stall_cnt), 0);
    cnt_clr = 0;
    step();
    chk("after_clr_cnt", 32'(stall_cnt), 1);

`ifdef HAZ_MDU_EN
    do_reset();
    id_src = {6'd0, 6'd3}; id_src_used = 2'b01;
    mdu_start = 1; mdu_rdes = 3;
    #1;
    chk("mdu_c0_stall", 32'(stall), 1);
    step();
    mdu_start = 0;
    for (int c = 1; c <= 5; c++) begin
      chk($sformatf("mdu_c%0d_stall", c), 32'(stall), 32'(c <= 4));
      chk($sformatf("mdu_c%0d_busy", c), 32'(mdu_busy), 32'(c <= 4));
      chk($sformatf("mdu_c%0d_done", c), 32'(mdu_done), 32'(c == 4));
      step();
    end

    do_reset();
    id_src = {6'd0, 6'd3}; id_src_used = 2'b01;
    mdu_start = 1; mdu_rdes = 3;
    step();
    mdu_start = 0;
    step();
    mdu_start = 1; mdu_rdes = 5;
    #1;
    chk("ovr_c2", 32'(mdu_ovr), 0);
    step();
    mdu_start = 0;
    for (int c = 3; c <= 6; c++) begin
      chk($sformatf("ovr_c%0d_ovr", c), 32'(mdu_ovr), 1);
      chk($sformatf("ovr_c%0d_done", c), 32'(mdu_done), 32'(c == 4));
      chk($sformatf("ovr_c%0d_stall", c), 32'(stall), 32'(c <= 4));
      step();
    end
    reset = 1;
    #1;
    chk("ovr_rst", 32'(mdu_ovr), 0);
    do_reset();

    id_src = {6'd0, 6'd3}; id_src_used = 2'b01;
    mdu_start = 1; mdu_rdes = 3;
    step();
    mdu_start = 0;
    step();
    chk("rmid_busy_pre", 32'(mdu_busy), 1);
    chk("rmid_cnt_pre", 32'(stall_cnt), 2);
    reset = 1;
    #1;
    chk("rmid_busy", 32'(mdu_busy), 0);
    chk("rmid_cnt", 32'(stall_cnt), 0);
    chk("rmid_stall", 32'(stall), 0);
    #2;
    reset = 0;
    for (int c = 3; c <= 7; c++) begin
      step();
      chk($sformatf("rmid_c%0d_done", c), 32'(mdu_done), 0);
      chk($sformatf("rmid_c%0d_busy", c), 32'(mdu_busy), 0);
    end
`else
    do_reset();
    id_src = {6'd0, 6'd3}; id_src_used = 2'b01;
    id_is_mdu = 1; mdu_start = 1; mdu_rdes = 3;
    #1;
    chk("nomdu_stall", 32'(stall), 0);
    for (int c = 1; c <= 6; c++) begin
      step();
      chk($sformatf("nomdu_c%0d_busy", c), 32'(mdu_busy), 0);
      chk($sformatf("nomdu_c%0d_done", c), 32'(mdu_done), 0);
      chk($sformatf("nomdu_c%0d_ovr", c), 32'(mdu_ovr), 0);
      chk($sformatf("nomdu_c%0d_stall", c), 32'(stall), 0);
    end
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
